// File: rtl/cb_vm_row_agd.sv
// Row address generator: streams row_len beats of (word address, bank) for one
// CB row, interleaving consecutive elements across 8 banks.
module cb_vm_row_agd #(
  parameter int unsigned CB_AW   = 17,
  parameter int unsigned ROW_LEN = 10
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               user_reset,
  input  logic               start,
  input  logic [ROW_LEN-1:0] row_len,
  input  logic               base_load,
  input  logic [CB_AW-1:0]   CB_base_addr,
  input  logic               addr_ready,
  output logic               addr_valid,
  output logic [CB_AW-1:0]   CB_addr,
  output logic [2:0]         CB_bank,
  output logic               addr_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BANK_W = 3;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BASE = 2'd1;
  localparam logic [1:0] S_STREAM    = 2'd2;
  localparam logic [1:0] S_FIN       = 2'd3;

  logic [1:0]         state, state_d;
  logic [ROW_LEN-1:0] len_r, len_d;
  logic [ROW_LEN-1:0] idx, idx_d, idx_inc;
  logic [CB_AW-1:0]   base_r, base_d;
  logic [CB_AW-1:0]   addr_d;
  logic [2:0]         bank_d;
  logic               valid_d, last_d;
  logic               clr;

  assign clr     = sys_rst | user_reset;
  assign idx_inc = idx + ROW_LEN'(1);

  // Next-state and next-output logic; beat outputs are precomputed so they
  // appear registered in the same cycle the FSM reaches the matching state.
  always_comb begin
    state_d = state;
    len_d   = len_r;
    idx_d   = idx;
    base_d  = base_r;
    valid_d = addr_valid;
    addr_d  = CB_addr;
    bank_d  = CB_bank;
    last_d  = addr_last;
    case (state)
      S_IDLE: begin
        if (start) begin
          len_d   = row_len;
          idx_d   = '0;
          state_d = (row_len == '0) ? S_FIN : S_WAIT_BASE;
        end
      end
      S_WAIT_BASE: begin
        if (base_load) begin
          base_d  = CB_base_addr;
          state_d = S_STREAM;
          valid_d = 1'b1;
          addr_d  = CB_base_addr;
          bank_d  = '0;
          last_d  = (len_r == ROW_LEN'(1));
        end
      end
      S_STREAM: begin
        if (addr_valid && addr_ready) begin
          if (addr_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            idx_d   = idx_inc;
            addr_d  = base_r + CB_AW'(idx_inc >> BANK_W);
            bank_d  = idx_inc[2:0];
            last_d  = (idx_inc == len_r - ROW_LEN'(1));
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      len_r      <= '0;
      idx        <= '0;
      base_r     <= '0;
      addr_valid <= 1'b0;
      CB_addr    <= '0;
      CB_bank    <= '0;
      addr_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      len_r      <= len_d;
      idx        <= idx_d;
      base_r     <= base_d;
      addr_valid <= valid_d;
      CB_addr    <= addr_d;
      CB_bank    <= bank_d;
      addr_last  <= last_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_FIN);
    end
  end

endmodule

// File: tb/tb_cb_vm_row_agd.sv
// Bench for cb_vm_row_agd: random and directed rows compared against a
// per-row list of expected (address, bank, last) beats.
module tb_cb_vm_row_agd;

  localparam int unsigned AW = 17;
  localparam int unsigned RL = 10;

  logic          clk = 1'b0;
  logic          sys_rst, user_reset, start, base_load, addr_ready;
  logic [RL-1:0] row_len;
  logic [AW-1:0] CB_base_addr;
  logic          addr_valid, addr_last, busy, done;
  logic [AW-1:0] CB_addr;
  logic [2:0]    CB_bank;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [20:0] obs[$];
  logic [20:0] exp_q[$];
  int n_done, valid_cycles, busy_cycles, stall_err;
  int base_at, first_valid_at, last_xfer, done_at, timeout;
  logic end_valid, end_busy, end_done;
  logic [AW-1:0] end_addr;
  logic [2:0] end_bank;

  cb_vm_row_agd #(.CB_AW(AW), .ROW_LEN(RL)) dut (
    .clk(clk), .sys_rst(sys_rst), .user_reset(user_reset), .start(start),
    .row_len(row_len), .base_load(base_load), .CB_base_addr(CB_base_addr),
    .addr_ready(addr_ready), .addr_valid(addr_valid), .CB_addr(CB_addr),
    .CB_bank(CB_bank), .addr_last(addr_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: element i lives in bank i mod 8 at word base + i/8 (mod 2^17).
  function automatic void model_row(input int len, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = AW'((int'(base) + i / 8) % (1 << AW));
      exp_q.push_back({a, 3'(i % 8), 1'(i == len - 1)});
    end
  endfunction

  // Drives one row and records what the DUT did; comparisons live in the tests.
  task automatic run_row(input int len, input logic [AW-1:0] base, input int pct,
                         input int bdelay, input logic [31:0] rpat, input int rplen,
                         input int start_at, input int rst_beats);
    logic pv, pr, pl, r;
    logic [AW-1:0] pa;
    logic [2:0] pb;
    int vi;
    obs.delete();
    n_done = 0; valid_cycles = 0; busy_cycles = 0; stall_err = 0;
    base_at = -1; first_valid_at = -1; last_xfer = -1; done_at = -1; timeout = 1;
    vi = 0; pv = 0; pr = 1; pl = 0; pa = '0; pb = '0;
    row_len = RL'(len); start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (pv && !pr && {addr_valid, CB_addr, CB_bank, addr_last} !== {pv, pa, pb, pl})
        stall_err++;
      if (addr_valid) begin
        valid_cycles++;
        if (first_valid_at < 0) first_valid_at = cyc;
      end
      if (done) begin n_done++; done_at = cyc; end
      if (!busy) begin timeout = 0; break; end
      busy_cycles++;
      base_load    = (k == bdelay);
      CB_base_addr = (k == bdelay) ? base : AW'($urandom);
      if (k == bdelay) base_at = cyc;
      start   = (k == start_at);
      row_len = RL'($urandom_range(1, 1023));
      if (rplen > 0) r = (vi < rplen) ? rpat[vi] : 1'b1;
      else r = ($urandom_range(0, 99) < pct);
      if (addr_valid) vi++;
      user_reset = (rst_beats >= 0) && addr_valid && (obs.size() == rst_beats);
      addr_ready = r;
      if (addr_valid && r && !user_reset) begin
        obs.push_back({CB_addr, CB_bank, addr_last});
        last_xfer = cyc;
      end
      pv = addr_valid; pr = r | user_reset; pa = CB_addr; pb = CB_bank; pl = addr_last;
      tick();
      user_reset = 1'b0;
    end
    end_valid = addr_valid; end_busy = busy; end_done = done;
    end_addr = CB_addr; end_bank = CB_bank;
    addr_ready = 1'b0; base_load = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b1; row_len = RL'(5); base_load = 1'b1; addr_ready = 1'b1;
    tick(); tick();
    sys_rst = 1'b0; start = 1'b0; base_load = 1'b0; addr_ready = 1'b0;
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", addr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (addr_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", addr_last); end
    checks++; if ({CB_addr, CB_bank} !== 20'h0) begin errors++; $display("FAIL reset_addr got %h want 0", {CB_addr, CB_bank}); end
  endtask

  task automatic test_basic();
    run_row(10, 17'h00100, 100, 0, 32'h0, 0, -1, -1);
    model_row(10, 17'h00100);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (first_valid_at != base_at + 1) begin errors++; $display("FAIL basic_first_valid got %0d want %0d", first_valid_at, base_at + 1); end
    checks++; if (done_at != last_xfer + 1 || n_done != 1) begin errors++; $display("FAIL basic_done got at %0d x%0d want at %0d x1", done_at, n_done, last_xfer + 1); end
    checks++; if (valid_cycles != 10 || busy_cycles != 12) begin errors++; $display("FAIL basic_cycles got v%0d b%0d want v10 b12", valid_cycles, busy_cycles); end
  endtask

  task automatic test_stall();
    run_row(3, 17'h00040, 0, 1, 32'b101001, 6, -1, -1);
    model_row(3, 17'h00040);
    checks++; if (obs.size() != 3) begin errors++; $display("FAIL stall_count got %0d want 3", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stall_err); end
    checks++; if (valid_cycles != 6 || n_done != 1) begin errors++; $display("FAIL stall_valid got v%0d d%0d want v6 d1", valid_cycles, n_done); end
  endtask

  task automatic test_zero_len();
    run_row(0, 17'h01234, 100, 0, 32'h0, 0, -1, -1);
    checks++; if (obs.size() != 0 || valid_cycles != 0) begin errors++; $display("FAIL zero_beats got %0d/%0d want 0/0", obs.size(), valid_cycles); end
    checks++; if (busy_cycles != 1) begin errors++; $display("FAIL zero_busy got %0d want 1", busy_cycles); end
    checks++; if (n_done != 1 || timeout != 0) begin errors++; $display("FAIL zero_done got %0d t%0d want 1 t0", n_done, timeout); end
  endtask

  task automatic test_wrap();
    run_row(9, 17'h1FFFF, 100, 0, 32'h0, 0, -1, -1);
    model_row(9, 17'h1FFFF);
    checks++; if (obs.size() != 9) begin errors++; $display("FAIL wrap_count got %0d want 9", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    if (obs.size() == 9) begin
      checks++; if (obs[8] !== {17'h00000, 3'd0, 1'b1}) begin errors++; $display("FAIL wrap_last got %h want %h", obs[8], {17'h00000, 3'd0, 1'b1}); end
    end
  endtask

  task automatic test_user_reset();
    run_row(16, 17'h00200, 100, 0, 32'h0, 0, -1, 4);
    checks++; if (obs.size() != 4) begin errors++; $display("FAIL ureset_beats got %0d want 4", obs.size()); end
    checks++; if (end_valid !== 1'b0 || end_busy !== 1'b0 || timeout != 0) begin errors++; $display("FAIL ureset_idle got v%b b%b t%0d want v0 b0 t0", end_valid, end_busy, timeout); end
    checks++; if (n_done != 0 || end_done !== 1'b0) begin errors++; $display("FAIL ureset_done got %0d want 0", n_done); end
    checks++; if ({end_addr, end_bank} !== 20'h0) begin errors++; $display("FAIL ureset_addr got %h want 0", {end_addr, end_bank}); end
    run_row(5, 17'h00300, 70, 2, 32'h0, 0, -1, -1);
    model_row(5, 17'h00300);
    checks++; if (obs.size() != 5 || n_done != 1) begin errors++; $display("FAIL ureset_after got %0d d%0d want 5 d1", obs.size(), n_done); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL ureset_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignore();
    base_load = 1'b1; CB_base_addr = 17'h15555;
    tick();
    base_load = 1'b0;
    checks++; if (busy !== 1'b0 || addr_valid !== 1'b0) begin errors++; $display("FAIL ign_idle got b%b v%b want b0 v0", busy, addr_valid); end
    run_row(12, 17'h0ABCD, 100, 2, 32'h0, 0, 5, -1);
    model_row(12, 17'h0ABCD);
    checks++; if (obs.size() != 12 || n_done != 1) begin errors++; $display("FAIL ign_count got %0d d%0d want 12 d1", obs.size(), n_done); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL ign_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [AW-1:0] base;
    for (int n = 0; n < 10; n++) begin
      len  = (n == 9) ? 1023 : int'($urandom_range(1, 40));
      base = AW'($urandom);
      run_row(len, base, (n == 9) ? 100 : int'($urandom_range(40, 100)),
              int'($urandom_range(0, 3)), 32'h0, 0, -1, -1);
      model_row(len, base);
      checks++; if (obs.size() != len || timeout != 0) begin errors++; $display("FAIL b2b%0d_count got %0d want %0d", n, obs.size(), len); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_beat%0d got %h want %h", n, i, obs[i], exp_q[i]); end
      end
      checks++; if (done_at != last_xfer + 1 || n_done != 1) begin errors++; $display("FAIL b2b%0d_done got at %0d x%0d want at %0d x1", n, done_at, n_done, last_xfer + 1); end
      checks++; if (stall_err != 0 || first_valid_at != base_at + 1) begin errors++; $display("FAIL b2b%0d_timing got s%0d f%0d want s0 f%0d", n, stall_err, first_valid_at, base_at + 1); end
    end
  endtask

  initial begin
    sys_rst = 1'b1; user_reset = 1'b0; start = 1'b0; base_load = 1'b0;
    addr_ready = 1'b0; row_len = '0; CB_base_addr = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_wrap();
    test_user_reset();
    test_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
